// File: rtl/gb_pkg.sv
// Shared Game Boy bus definitions: bus-owner states, machine-cycle length and
// the cartridge/memory region map used by the sequencer, CPU core and DMA engine.
package gb_pkg;

    // Owner of the external bus for one M-cycle
    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_CPU_RD = 2'd1,
        BUS_CPU_WR = 2'd2,
        BUS_DMA_RD = 2'd3
    } bus_state_t;

    // T-cycles per M-cycle
    localparam int unsigned T_PER_M = 4;

    // Memory map regions
    localparam logic [15:0] ROM_LO   = 16'h0000;
    localparam logic [15:0] ROM_HI   = 16'h7FFF;
    localparam logic [15:0] ERAM_LO  = 16'hA000;
    localparam logic [15:0] ERAM_HI  = 16'hBFFF;
    localparam logic [15:0] WRAM_LO  = 16'hC000;
    localparam logic [15:0] WRAM_HI  = 16'hDFFF;
    localparam logic [15:0] ECHO_LO  = 16'hE000;
    localparam logic [15:0] ECHO_HI  = 16'hFDFF;
    localparam logic [15:0] OAM_BASE = 16'hFE00;

    // Inclusive address window test
    function automatic logic addr_in_range(input logic [15:0] a,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // True for states that pull RD low for the whole M-cycle
    function automatic logic is_read_state(input bus_state_t s);
        return (s == BUS_CPU_RD) || (s == BUS_DMA_RD);
    endfunction

endpackage

// File: rtl/gb_tcycle_gen.sv
// T-cycle generator: divides the system clock into T-cycles and groups them
// into 4-T M-cycles. Provides the M-cycle start pulse, the last-tick strobe,
// the next-tick T-cycle value (for registered output decode) and the PHI clock.
module gb_tcycle_gen
    import gb_pkg::*;
#(
    parameter int unsigned T_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] tcycle,
    output logic [1:0] tcycle_next,
    output logic       m_start,
    output logic       last_tick,
    output logic       clock
);

    localparam int unsigned    DW       = (T_DIV > 1) ? $clog2(T_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(T_DIV - 1);
    localparam logic [1:0]     T_LAST   = 2'(T_PER_M - 1);

    logic [DW-1:0] div;
    logic          t_end;

    assign t_end     = (div == DIV_LAST);
    assign m_start   = (tcycle == 2'd0) && (div == '0);
    assign last_tick = (tcycle == T_LAST) && t_end;

    // T-cycle value that will be current after the next clock edge
    always_comb begin
        tcycle_next = tcycle;
        if (t_end) begin
            tcycle_next = (tcycle == T_LAST) ? 2'd0 : tcycle + 2'd1;
        end
    end

    // Divider and T-cycle counters; PHI is registered from the next T-cycle so it tracks tcycle exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            div    <= '0;
            tcycle <= '0;
            clock  <= 1'b1;
        end else begin
            div    <= t_end ? '0 : div + DW'(1);
            tcycle <= tcycle_next;
            clock  <= ~tcycle_next[1];
        end
    end

endmodule

// File: rtl/gb_bus_sequencer.sv
// Machine-cycle bus sequencer: grants each M-cycle to the DMA engine or the
// CPU core, latches the winner's address/data at the M-cycle boundary and
// drives the cartridge pins. All pin outputs are registered from the state
// and T-cycle that will be current after the clock edge, so they change in
// step with tcycle and never glitch on requester input changes.
module gb_bus_sequencer
    import gb_pkg::*;
#(
    parameter int unsigned T_DIV = 2,
    parameter logic [15:0] CS_LO = ERAM_LO,
    parameter logic [15:0] CS_HI = ECHO_HI
) (
    input  logic        pllClk,
    input  logic        reset,
    output logic [1:0]  tcycle,
    output logic        m_start,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] add,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        read_n,
    output logic        write_n,
    output logic        chip_n,
    output logic        clock
);

    logic [1:0]  tcycle_next;
    logic        last_tick;
    bus_state_t  state;
    bus_state_t  sel;
    bus_state_t  state_next;
    logic [15:0] addr_next;

    gb_tcycle_gen #(
        .T_DIV(T_DIV)
    ) u_tgen (
        .clk        (pllClk),
        .reset      (reset),
        .tcycle     (tcycle),
        .tcycle_next(tcycle_next),
        .m_start    (m_start),
        .last_tick  (last_tick),
        .clock      (clock)
    );

    // Arbitration (DMA over CPU write over CPU read) and next address; only committed on the last tick
    always_comb begin
        sel        = BUS_IDLE;
        state_next = state;
        addr_next  = add;
        if (dma_req) begin
            sel = BUS_DMA_RD;
        end else if (cpu_req && cpu_we) begin
            sel = BUS_CPU_WR;
        end else if (cpu_req) begin
            sel = BUS_CPU_RD;
        end
        if (last_tick) begin
            state_next = sel;
            case (sel)
                BUS_DMA_RD:             addr_next = dma_addr;
                BUS_CPU_RD, BUS_CPU_WR: addr_next = cpu_addr;
                default:                addr_next = add;
            endcase
        end
    end

    // Bus state machine with registered pin outputs, acks and read-data capture
    always_ff @(posedge pllClk) begin
        if (reset) begin
            state     <= BUS_IDLE;
            add       <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            read_n    <= 1'b1;
            write_n   <= 1'b1;
            chip_n    <= 1'b1;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state   <= state_next;
            add     <= addr_next;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (last_tick) begin
                // Completion of the M-cycle now ending
                case (state)
                    BUS_CPU_RD: begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= data_in;
                    end
                    BUS_CPU_WR: begin
                        cpu_ack <= 1'b1;
                    end
                    BUS_DMA_RD: begin
                        dma_ack   <= 1'b1;
                        dma_rdata <= data_in;
                    end
                    default: ;
                endcase
                if (sel == BUS_CPU_WR) begin
                    data_out <= cpu_wdata;
                end
            end
            read_n  <= ~is_read_state(state_next);
            write_n <= ~((state_next == BUS_CPU_WR) && tcycle_next[1]);
            data_oe <= (state_next == BUS_CPU_WR) && (tcycle_next != 2'd0);
            chip_n  <= ~((state_next != BUS_IDLE) && addr_in_range(addr_next, CS_LO, CS_HI));
        end
    end

endmodule

// File: tb/tb_gb_bus_sequencer.sv
// Self-checking bench for gb_bus_sequencer: a tick-level reference model
// (M-cycle grants computed from tick count and sampled requests) checked on
// every falling edge, a table of single CPU transactions, hand-written
// multi-cycle sequences and a randomized phase with occasional resets.
module tb_gb_bus_sequencer;

    localparam int unsigned TD = 2;
    localparam int unsigned MT = 4 * TD;
    localparam int G_IDLE = 0;
    localparam int G_RD   = 1;
    localparam int G_WR   = 2;
    localparam int G_DMA  = 3;

    logic        pllClk;
    logic        reset;
    logic [1:0]  tcycle;
    logic        m_start;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] add;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        read_n;
    logic        write_n;
    logic        chip_n;
    logic        clock;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    gb_bus_sequencer #(
        .T_DIV(TD),
        .CS_LO(16'hA000),
        .CS_HI(16'hFDFF)
    ) dut (
        .pllClk   (pllClk),
        .reset    (reset),
        .tcycle   (tcycle),
        .m_start  (m_start),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .dma_req  (dma_req),
        .dma_addr (dma_addr),
        .dma_ack  (dma_ack),
        .dma_rdata(dma_rdata),
        .add      (add),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .read_n   (read_n),
        .write_n  (write_n),
        .chip_n   (chip_n),
        .clock    (clock)
    );

    initial pllClk = 1'b0;
    always #5 pllClk = ~pllClk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned n = 0;
    int          grant = G_IDLE;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_crd = '0;
    logic [7:0]  m_drd = '0;
    logic        m_cack = 1'b0;
    logic        m_dack = 1'b0;
    bit          model_valid = 1'b0;

    // Model advances one tick per rising edge using the inputs held since the falling edge
    always @(posedge pllClk) begin
        if (reset) begin
            n = 0; grant = G_IDLE; m_addr = '0; m_wdata = '0;
            m_crd = '0; m_drd = '0; m_cack = 1'b0; m_dack = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_cack = 1'b0;
            m_dack = 1'b0;
            if (n % MT == MT - 1) begin
                if (grant == G_RD)  begin m_cack = 1'b1; m_crd = data_in; end
                if (grant == G_WR)  m_cack = 1'b1;
                if (grant == G_DMA) begin m_dack = 1'b1; m_drd = data_in; end
                if (dma_req) begin
                    grant = G_DMA; m_addr = dma_addr;
                end else if (cpu_req) begin
                    grant = cpu_we ? G_WR : G_RD;
                    m_addr = cpu_addr;
                    if (cpu_we) m_wdata = cpu_wdata;
                end else begin
                    grant = G_IDLE;
                end
            end
            n++;
        end
    end

    // Compare every DUT output with the model on each falling edge
    always @(negedge pllClk) begin
        int unsigned tc;
        if (model_valid) begin
            tc = (n / TD) % 4;
            chk("m_tcycle", {14'd0, tcycle}, 16'(tc));
            chk("m_start", m_start, n % MT == 0);
            chk("m_clock", clock, tc < 2);
            chk("m_add", add, m_addr);
            chk("m_read_n", read_n, !(grant == G_RD || grant == G_DMA));
            chk("m_write_n", write_n, !(grant == G_WR && tc >= 2));
            chk("m_data_oe", data_oe, grant == G_WR && tc >= 1);
            if (grant == G_WR && tc >= 1) chk("m_data_out", data_out, m_wdata);
            chk("m_chip_n", chip_n,
                !(grant != G_IDLE && m_addr >= 16'hA000 && m_addr <= 16'hFDFF));
            chk("m_cpu_ack", cpu_ack, m_cack);
            chk("m_dma_ack", dma_ack, m_dack);
            chk("m_cpu_rdata", cpu_rdata, m_crd);
            chk("m_dma_rdata", dma_rdata, m_drd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_last();
        int unsigned k = 0;
        @(negedge pllClk);
        while (n % MT != MT - 1 && k < 2 * MT) begin
            @(negedge pllClk);
            k++;
        end
        if (n % MT != MT - 1) begin
            checks++;
            failures++;
            $display("FAIL wait_last: got no last tick within %0d ticks", k);
        end
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 16'h9FFF;
            1: return 16'hA000;
            2: return 16'hFDFF;
            3: return 16'hFE00;
            default: return 16'($urandom);
        endcase
    endfunction

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic        exp_chip_n;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dacks[$];
        int cacks[$];
        logic [15:0] adds[3];
        int unsigned ackcnt;

        vecs[0] = '{1'b0, 16'h0150, 8'h00, 8'h3E, 1'b1, 8'h3E};
        vecs[1] = '{1'b1, 16'hA010, 8'h5A, 8'h00, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 16'h9FFF, 8'h00, 8'h11, 1'b1, 8'h11};
        vecs[3] = '{1'b0, 16'hA000, 8'h00, 8'h22, 1'b0, 8'h22};
        vecs[4] = '{1'b0, 16'hFDFF, 8'h00, 8'h33, 1'b0, 8'h33};
        vecs[5] = '{1'b0, 16'hFE00, 8'h00, 8'h44, 1'b1, 8'h44};
        vecs[6] = '{1'b1, 16'hFFFF, 8'hA5, 8'h00, 1'b1, 8'h00};
        vecs[7] = '{1'b0, 16'hC000, 8'h00, 8'h77, 1'b0, 8'h77};

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_addr = '0; data_in = '0;
        repeat (3) @(negedge pllClk);
        chk("rst_add", add, 16'h0000);
        chk("rst_read_n", read_n, 1'b1);
        chk("rst_clock", clock, 1'b1);
        chk("rst_tcycle", {14'd0, tcycle}, 16'd0);
        reset = 1'b0;

        // 1: idle M-cycles after reset
        for (int j = 0; j < 64; j++) begin
            @(negedge pllClk);
            chk("t1_tcycle", {14'd0, tcycle}, 16'(((j + 1) / 2) % 4));
            chk("t1_clock", clock, ((j + 1) / 2) % 4 < 2);
            chk("t1_pins", {read_n, write_n, chip_n}, 3'b111);
            chk("t1_acks", {cpu_ack, dma_ack}, 2'b00);
        end

        // 2/3: single CPU transactions from the table
        for (int v = 0; v < 8; v++) begin
            wait_last();
            cpu_req = 1'b1; cpu_we = vecs[v].we; cpu_addr = vecs[v].addr;
            cpu_wdata = vecs[v].wdata; data_in = vecs[v].din;
            for (int k = 0; k <= 8; k++) begin
                @(negedge pllClk);
                if (k < 8) begin
                    chk("v_add", add, vecs[v].addr);
                    chk("v_chip_n", chip_n, vecs[v].exp_chip_n);
                    chk("v_read_n", read_n, vecs[v].we);
                    chk("v_write_n", write_n, !(vecs[v].we && k >= 4));
                    chk("v_data_oe", data_oe, vecs[v].we && k >= 2);
                    if (vecs[v].we && k >= 2) chk("v_data_out", data_out, vecs[v].wdata);
                    chk("v_ack_early", cpu_ack, 1'b0);
                end else begin
                    chk("v_ack", cpu_ack, 1'b1);
                    if (!vecs[v].we) chk("v_rdata", cpu_rdata, vecs[v].exp_rdata);
                end
                if (k == 0) begin
                    cpu_req = 1'b0;
                    cpu_addr = ~vecs[v].addr;
                    cpu_wdata = ~vecs[v].wdata;
                end
            end
        end

        // 4: DMA and CPU raised together, DMA held two M-cycles
        wait_last();
        dma_req = 1'b1; dma_addr = 16'hC100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200; data_in = 8'h99;
        for (int j = 0; j <= 24; j++) begin
            @(negedge pllClk);
            if (j % 8 == 3 && j < 24) adds[j / 8] = add;
            if (dma_ack) dacks.push_back(j);
            if (cpu_ack) cacks.push_back(j);
            if (j == 8) dma_req = 1'b0;
            if (j == 16) cpu_req = 1'b0;
        end
        chk("t4_add0", adds[0], 16'hC100);
        chk("t4_add1", adds[1], 16'hC100);
        chk("t4_add2", adds[2], 16'h0200);
        chk("t4_dma_ack_count", 16'(dacks.size()), 16'd2);
        chk("t4_cpu_ack_count", 16'(cacks.size()), 16'd1);
        if (dacks.size() == 2) begin
            chk("t4_dma_ack0_tick", 16'(dacks[0]), 16'd8);
            chk("t4_dma_ack1_tick", 16'(dacks[1]), 16'd16);
        end
        if (cacks.size() == 1) chk("t4_cpu_ack_tick", 16'(cacks[0]), 16'd24);

        // 5: reset during T2 of a CPU write
        wait_last();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hA010; cpu_wdata = 8'hC3;
        @(negedge pllClk);
        cpu_req = 1'b0;
        repeat (4) @(negedge pllClk);
        chk("t5_pre_tcycle", {14'd0, tcycle}, 16'd2);
        chk("t5_pre_write_n", write_n, 1'b0);
        reset = 1'b1;
        @(negedge pllClk);
        chk("t5_write_n", write_n, 1'b1);
        chk("t5_data_oe", data_oe, 1'b0);
        chk("t5_tcycle", {14'd0, tcycle}, 16'd0);
        reset = 1'b0;
        ackcnt = 0;
        for (int j = 0; j < 24; j++) begin
            @(negedge pllClk);
            if (cpu_ack) ackcnt++;
        end
        chk("t5_no_ack", 16'(ackcnt), 16'd0);

        // 6: back-to-back CPU reads
        dacks.delete();
        cacks.delete();
        wait_last();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; data_in = 8'h10;
        for (int j = 0; j <= 24; j++) begin
            @(negedge pllClk);
            if (j < 24) chk("t6_read_n", read_n, 1'b0);
            if (cpu_ack) cacks.push_back(j);
            if (j == 0) cpu_addr = 16'h0101;
            if (j == 8) cpu_addr = 16'h0102;
            if (j == 16) cpu_req = 1'b0;
        end
        chk("t6_ack_count", 16'(cacks.size()), 16'd3);
        if (cacks.size() == 3) begin
            chk("t6_ack0_tick", 16'(cacks[0]), 16'd8);
            chk("t6_gap1", 16'(cacks[1] - cacks[0]), 16'd8);
            chk("t6_gap2", 16'(cacks[2] - cacks[1]), 16'd8);
        end

        // randomized traffic against the model, requests may change at any tick
        for (int i = 0; i < 2400; i++) begin
            @(negedge pllClk);
            data_in = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                dma_req   = ($urandom_range(0, 3) == 0);
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = pick_addr();
                dma_addr  = pick_addr();
                cpu_wdata = 8'($urandom);
            end
            reset = ($urandom_range(0, 399) == 0);
        end
        reset = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        repeat (16) @(negedge pllClk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_bus_sequencer.md
Name: gb_bus_sequencer

Overview:
- Machine-cycle timing generator and external-bus arbiter for the Game Boy CPU.
- Divides pllClk into T-cycles, with 4 T-cycles per M-cycle.
- Grants each M-cycle to one requester: the OAM DMA engine or the CPU core.
- Drives the cartridge bus pins (address, data, read, write, chip-select, clock), so the CPU decode logic no longer touches the pins directly.

Parameters:
- T_DIV, 2: pllClk ticks per T-cycle. 2^23 Hz / 2 gives the 2^22 Hz DMG T-clock.
- CS_LO, 16'hA000: lowest address that asserts chip_n.
- CS_HI, 16'hFDFF: highest address that asserts chip_n.

Ports:
- pllClk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tcycle  out  2  current T-cycle within the M-cycle (0..3)
- m_start  out  1  one-pllClk pulse on the first tick of T0
- cpu_req  in  1  CPU bus request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-pllClk pulse marking transaction completion
- cpu_rdata  out  8  read data; valid with cpu_ack and held until the next read
- dma_req  in  1  DMA read request; held until dma_ack
- dma_addr  in  16  DMA source address
- dma_ack  out  1  one-pllClk completion pulse
- dma_rdata  out  8  DMA read data; valid with dma_ack
- add  out  16  cartridge address pins
- data_in  in  8  cartridge data pins (input side)
- data_out  out  8  cartridge data pins (output side)
- data_oe  out  1  1 = drive data_out onto the pins
- read_n  out  1  cartridge RD, active low
- write_n  out  1  cartridge WR, active low
- chip_n  out  1  cartridge CS, active low
- clock  out  1  cartridge PHI: high during T0–T1, low during T2–T3

Behaviour:
- Timing counters:
  - div counts 0..T_DIV-1; tcycle advances when div == T_DIV-1 and wraps from 3 to 0.
  - m_start = (tcycle == 0 && div == 0).
  - The "last tick" is tcycle == 3 && div == T_DIV-1.
- State machine: IDLE, CPU_RD, CPU_WR, DMA_RD.
  - The state changes only on the last tick, so it is held for exactly one M-cycle.
- Next-state selection on the last tick, in priority order:
  - dma_req → DMA_RD; otherwise
  - cpu_req and cpu_we → CPU_WR; otherwise
  - cpu_req → CPU_RD; otherwise
  - IDLE.
  - Requests are sampled only on the last tick. A request raised mid-M-cycle waits for the next boundary.
- Address latch: on the last tick, the winner's address (and cpu_wdata for writes) is captured into internal registers. add is driven from the latch for the whole M-cycle. Requester inputs may change after ack without glitching the pins.
- Read states (CPU_RD, DMA_RD):
  - read_n = 0 for T0–T3; write_n = 1; data_oe = 0.
  - data_in is sampled on the last tick into cpu_rdata or dma_rdata.
  - The matching ack pulses high on that same last tick (registered; visible the following pllClk).
- CPU_WR:
  - read_n = 1.
  - data_oe = 1 and data_out = latched wdata for T1–T3.
  - write_n = 0 for T2–T3 only.
  - cpu_ack pulses as for reads.
- IDLE: read_n = 1, write_n = 1, data_oe = 0, chip_n = 1; add holds its last value.
- chip_n: 0 during any non-IDLE M-cycle whose latched address is in CS_LO..CS_HI inclusive; otherwise 1.
- Latency:
  - Request asserted on or before the last tick → ack exactly 4*T_DIV pllClk later.
  - Back-to-back requests run in consecutive M-cycles with no idle gap.
- Arbitration:
  - A CPU stalled by DMA keeps cpu_req high; it wins the first boundary where dma_req is low.
  - There is never more than one ack per M-cycle.
- Reset (including mid-transaction):
  - div = 0, tcycle = 0, state IDLE.
  - add = 16'h0000, data_out = 8'h00, data_oe = 0, read_n = 1, write_n = 1, chip_n = 1, clock = 1.
  - cpu_ack = 0, dma_ack = 0, cpu_rdata = 8'h00, dma_rdata = 8'h00.
  - An aborted transaction never acks; the requester re-requests.
  - The first M-cycle after reset is IDLE. Requests are first sampled on its last tick.
- Wrap-around: tcycle wraps from 3 to 0 and div from T_DIV-1 to 0 without extra ticks. Address arithmetic is not performed here.

Decomposition:
- Shared package gb_pkg:
  - bus state encoding (IDLE/CPU_RD/CPU_WR/DMA_RD);
  - T_PER_M = 4;
  - cartridge region constants (ROM 0000–7FFF, ext RAM A000–BFFF, WRAM C000–DFFF, echo E000–FDFF, OAM FE00).
  - The CPU core and DMA engine reuse these constants.
- One sub-module, gb_tcycle_gen: the div/tcycle counters, m_start, last-tick and clock generation. Reused by the PPU/timer blocks.

Test Plan:
1. Reset released, no requests, 8 M-cycles → tcycle sequences 0,1,2,3 every 2 pllClk; clock high for 4 pllClk then low for 4; read_n, write_n and chip_n stay 1; no acks.
2. CPU read at 0x0150, data_in = 0x3E → add = 0x0150 for the whole next M-cycle; read_n = 0; chip_n = 1; cpu_ack exactly 8 pllClk after the sampling tick; cpu_rdata = 0x3E.
3. CPU write of 0x5A to 0xA010 → chip_n = 0; data_oe = 1 for T1–T3; write_n = 0 in T2–T3 only; data_out = 0x5A; one cpu_ack.
4. dma_req (0xC100) and cpu_req (0x0200) raised in the same cycle, DMA held for 2 M-cycles → 2 dma_acks first, then a cpu_ack in the 3rd M-cycle; add sequence 0xC100, 0xC100, 0x0200.
5. reset asserted during T2 of a CPU_WR → next cycle write_n = 1, data_oe = 0, tcycle = 0; no cpu_ack ever issued for that write.
6. Back-to-back CPU reads at 0x0100, 0x0101, 0x0102 → three acks exactly 8 pllClk apart; read_n stays 0 continuously.
